// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared FSM states, default width and counter sizing
package serial_add_ctrl_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// fa_bit: one-bit combinational full adder
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder driven by an IDLE/SHIFT/DONE FSM
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);
  localparam int CW = cnt_w(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0] cnt;
  logic carry, s, co;
  fa_bit u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(s), .co(co));
  // FSM, datapath shift registers and registered outputs; outputs only load when leaving DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_sr  <= a_in;
          b_sr  <= b_in;
          carry <= cin_in;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          res   <= {s, res[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= co;
          cnt   <= cnt + CW'(1);
          state <= (cnt == CW'(WIDTH - 1)) ? DONE : SHIFT;
        end
        DONE: begin
          sum_out  <= res;
          cout_out <= carry;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: table, directed and random checks of serial_add_ctrl against arithmetic model
module tb_serial_add_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin_in = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic busy, done, cout_out;
  logic [7:0] sum_out;
  int checks = 0, failures = 0;
  typedef struct {
    logic [7:0] a, b;
    logic c;
    logic [7:0] s;
    logic co;
  } vec_t;
  vec_t tv[6];
  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic eco, input bit scramble);
    int n, bc;
    logic [7:0] ps;
    logic pc;
    bit stable;
    @(negedge clk);
    ps = sum_out; pc = cout_out;
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; bc = 0; stable = 1;
    while (!done && n < 20) begin
      if (busy) bc++;
      if (sum_out !== ps || cout_out !== pc) stable = 0;
      if (scramble) begin
        a_in = 8'($urandom); b_in = 8'($urandom); cin_in = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, 9);
    chk({nm, "_busy_cycles"}, bc, 9);
    chk({nm, "_hold"}, {31'b0, stable}, 1);
    chk({nm, "_sum"}, sum_out, es);
    chk({nm, "_cout"}, cout_out, eco);
    chk({nm, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    chk({nm, "_done_width"}, done, 0);
  endtask
  initial begin
    logic [8:0] exp;
    logic [7:0] ra, rb;
    logic rc;
    int n, nd, t0;
    int dt[$];
    tv[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tv[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tv[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tv[4] = '{8'h3C, 8'h11, 1'b0, 8'h4D, 1'b0};
    tv[5] = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum_out, 0);
    chk("reset_cout", cout_out, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].c, tv[i].s, tv[i].co, 1'b0);
    @(negedge clk);
    a_in = 8'h3C; b_in = 8'h11; cin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a_in = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 4; nd = 0; t0 = -1;
    while (n < 30) begin
      if (done) begin
        nd++;
        if (t0 < 0) t0 = n;
        chk("ignore_start_sum", sum_out, 8'h4D);
        chk("ignore_start_cout", cout_out, 0);
      end
      @(negedge clk);
      n++;
    end
    chk("ignore_start_dones", nd, 1);
    chk("ignore_start_latency", t0, 9);
    @(negedge clk);
    a_in = 8'h0F; b_in = 8'h01; cin_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum_out, 0);
    chk("abort_cout", cout_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_sum_held", sum_out, 0);
    run_op("after_reset", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    @(negedge clk);
    a_in = 8'h80; b_in = 8'h80; cin_in = 1'b0; start = 1'b1;
    n = 0;
    while (n < 45 && dt.size() < 4) begin
      @(negedge clk);
      n++;
      if (done) begin
        dt.push_back(n);
        chk("b2b_sum", sum_out, 8'h00);
        chk("b2b_cout", cout_out, 1);
      end
    end
    start = 1'b0;
    chk("b2b_count", dt.size(), 4);
    chk("b2b_first", dt.size() > 0 ? dt[0] : -1, 10);
    for (int i = 1; i < dt.size(); i++) chk("b2b_period", dt[i] - dt[i-1], 10);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = 9'(ra) + 9'(rb) + 9'(rc);
      run_op($sformatf("rand%0d", i), ra, rb, rc, exp[7:0], exp[8], 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a_in  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: b_in  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: cin_in  input  1  carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 Port: done  output  1  single-cycle pulse marking result valid.
REQ-010 Port: sum_out  output  WIDTH  registered sum; holds until the next completion.
REQ-011 Port: cout_out  output  1  registered carry-out; holds until the next completion.

Function
REQ-012 The block SHALL compute {cout_out,sum_out} = a_in + b_in + cin_in bit-serially, LSB first, using exactly one 1-bit full-adder instance.
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1: latch a_in, b_in into shift registers; latch cin_in into the carry register; clear the bit counter; go to SHIFT.
REQ-015 IDLE with start=0: remain in IDLE; all registers hold.
REQ-016 Each SHIFT cycle SHALL feed the operand LSBs and the carry register to the full adder.
REQ-017 Each SHIFT cycle SHALL shift the sum bit into the result-register MSB, right-shift both operands, load the carry register with the adder carry-out, and increment the counter.
REQ-018 SHIFT SHALL last exactly WIDTH cycles; after the cycle with counter = WIDTH-1, go to DONE.
REQ-019 On entry to DONE, sum_out and cout_out SHALL load the result register and the final carry.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle; the next state is IDLE unconditionally.
REQ-021 Latency: if start is accepted at edge t, done SHALL be high in the cycle after edge t+WIDTH+1. The next start SHALL be accepted no earlier than edge t+WIDTH+2.
REQ-022 start SHALL be ignored while in SHIFT or DONE; no queuing, and the in-flight operation is unaffected.
REQ-023 Changes to a_in, b_in or cin_in after acceptance SHALL NOT affect the in-flight result.
REQ-024 sum_out and cout_out SHALL NOT change except on entry to DONE; intermediate SHIFT values SHALL never be visible on them.
REQ-025 Counter width SHALL be clog2(WIDTH)+1 bits; the counter SHALL NOT wrap within an operation.
REQ-026 All-ones + all-ones + 1 SHALL produce sum_out all-ones and cout_out=1, with no overflow of the internal state.

Reset
REQ-027 On rst_n=0, independent of clk, state SHALL be IDLE.
REQ-028 On rst_n=0, busy=0, done=0, sum_out=0, cout_out=0, and the counter, carry and shift registers SHALL be 0.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse and no output update.
REQ-030 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration (IDLE, SHIFT, DONE), the default WIDTH constant, and the counter-width function.
REQ-032 The 1-bit full adder SHALL be a separate combinational sub-module, fa_bit, with inputs a, b, ci and outputs s, co.
REQ-033 All other logic (FSM, counter, shift registers, output registers) SHALL reside in serial_add_ctrl.

Verification (WIDTH=8)
REQ-034 Start with A=0x00, B=0x00, Cin=0 -> done pulse 9 cycles after acceptance, sum_out=0x00, cout_out=0.
REQ-035 Start with A=0xFF, B=0x01, Cin=0 -> sum_out=0x00, cout_out=1; busy high for 9 cycles.
REQ-036 Start with A=0xA5, B=0x5A, Cin=1 -> sum_out=0x00, cout_out=1.
REQ-037 Start with A=0x3C, B=0x11; pulse start with A=0xFF during SHIFT -> single done, sum_out=0x4D, cout_out=0.
REQ-038 Start with A=0x0F, B=0x01, Cin=1 -> sum_out=0x11, cout_out=0; then assert rst_n=0 at SHIFT cycle 4 -> outputs 0, busy=0, no done pulse.
REQ-039 Back-to-back: start held high continuously with A=0x80, B=0x80, Cin=0 -> operations accepted every 10 cycles, each giving sum_out=0x00, cout_out=1.
